hex_display_scanner: RTL and testbench

Time-multiplexed driver for a bank of common-anode seven-segment displays. It latches a multi-digit hex value, scans one digit at a time at a programmable refresh rate, and drives the shared active-low segment bus and per-digit active-low anode enables. It replaces per-digit static hex decoders on the board I/O path and offers optional leading-zero blanking and digit blink.

---
 rtl/hex_disp_pkg.sv | 25 ++
 rtl/hex_seg_lut.sv | 32 +++
 rtl/hex_display_scanner.sv | 125 ++++++++++++
 tb/tb_hex_display_scanner.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/hex_disp_pkg.sv
// Shared segment type and active-low a..g glyph constants for the hex scanner.
package hex_disp_pkg;

    // seg[0] is segment a, so the literals below read a..g left to right.
    typedef logic [0:6] seg_t;

    localparam seg_t SEG_0     = 7'b0000001;
    localparam seg_t SEG_1     = 7'b1001111;
    localparam seg_t SEG_2     = 7'b0010010;
    localparam seg_t SEG_3     = 7'b0000110;
    localparam seg_t SEG_4     = 7'b1001100;
    localparam seg_t SEG_5     = 7'b0100100;
    localparam seg_t SEG_6     = 7'b0100000;
    localparam seg_t SEG_7     = 7'b0001111;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0000100;
    localparam seg_t SEG_A     = 7'b0001000;
    localparam seg_t SEG_B     = 7'b1100000;
    localparam seg_t SEG_C     = 7'b0110001;
    localparam seg_t SEG_D     = 7'b1000010;
    localparam seg_t SEG_E     = 7'b0110000;
    localparam seg_t SEG_F     = 7'b0111000;
    localparam seg_t SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/hex_seg_lut.sv
// Combinational nibble to active-low seven-segment glyph decoder.
module hex_seg_lut
    import hex_disp_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       glyph
);

    always_comb begin
        glyph = SEG_BLANK;
        case (nibble)
            4'h0: glyph = SEG_0;
            4'h1: glyph = SEG_1;
            4'h2: glyph = SEG_2;
            4'h3: glyph = SEG_3;
            4'h4: glyph = SEG_4;
            4'h5: glyph = SEG_5;
            4'h6: glyph = SEG_6;
            4'h7: glyph = SEG_7;
            4'h8: glyph = SEG_8;
            4'h9: glyph = SEG_9;
            4'hA: glyph = SEG_A;
            4'hB: glyph = SEG_B;
            4'hC: glyph = SEG_C;
            4'hD: glyph = SEG_D;
            4'hE: glyph = SEG_E;
            4'hF: glyph = SEG_F;
            default: glyph = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexed common-anode hex display driver with leading-zero blanking.
// Define HEX_BLINK_EN to add the blink_mask port and per-digit blink.
module hex_display_scanner
    import hex_disp_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_DIV   = 25000000,
    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
)
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic                    lz_blank,
`ifdef HEX_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
    output seg_t                    seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [IDX_W-1:0]        digit_idx
);

    localparam int               TICK_W    = $clog2(REFRESH_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [TICK_W-1:0]       tick;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic                    idx_change;
    logic [NUM_DIGITS-1:0]   lz_vec;
    logic [NUM_DIGITS-1:0]   blink_vec;
    logic                    zero_run;
    logic [3:0]              cur_nib;
    logic                    cur_blank;
    seg_t                    cur_glyph;

    assign idx_change = (tick == TICK_LAST);

    // Stage p0: scan counters and shadow register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick   <= '0;
            idx    <= '0;
            shadow <= '0;
        end else begin
            if (load)
                shadow <= value;
            if (idx_change) begin
                tick <= '0;
                idx  <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                tick <= tick + 1'b1;
            end
        end
    end

`ifdef HEX_BLINK_EN
    localparam int                BLINK_W    = $clog2(BLINK_DIV);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_on;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign blink_vec = blink_on ? '0 : blink_mask;
`else
    assign blink_vec = '0;
`endif

    // Walk from the top digit down: a digit is a leading zero while every digit above it is zero too.
    always_comb begin
        zero_run  = 1'b1;
        lz_vec    = '0;
        cur_nib   = '0;
        cur_blank = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run  = zero_run & (shadow[4*k +: 4] == 4'h0);
            lz_vec[k] = zero_run & (k != 0);
        end
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_nib   = shadow[4*k +: 4];
                cur_blank = (lz_blank & lz_vec[k]) | blink_vec[k];
            end
        end
    end

    hex_seg_lut u_lut (
        .nibble (cur_nib),
        .glyph  (cur_glyph)
    );

    // Stage p1: registered outputs; the index-change cycle is dark to avoid ghosting
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg       <= SEG_BLANK;
            an        <= '1;
            digit_idx <= '0;
        end else begin
            digit_idx <= idx;
            if (idx_change) begin
                seg <= SEG_BLANK;
                an  <= '1;
            end else begin
                seg <= cur_blank ? SEG_BLANK : cur_glyph;
                an  <= ~(NUM_DIGITS'(1) << idx);
            end
        end
    end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Scoreboard bench for hex_display_scanner (NUM_DIGITS=4, REFRESH_DIV=4, BLINK_DIV=8).
module tb_hex_display_scanner;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] value;
    logic        load;
    logic        lz_blank;
`ifdef HEX_BLINK_EN
    logic [3:0]  blink_mask;
`endif
    logic [0:6]  seg;
    logic [3:0]  an;
    logic [1:0]  digit_idx;

    int n_checks = 0;
    int n_fail   = 0;

    hex_display_scanner #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (4),
        .BLINK_DIV   (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .value      (value),
        .load       (load),
        .lz_blank   (lz_blank),
`ifdef HEX_BLINK_EN
        .blink_mask (blink_mask),
`endif
        .seg        (seg),
        .an         (an),
        .digit_idx  (digit_idx)
    );

    always #5 clk = ~clk;

    logic [6:0] glyph_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model and scoreboard
    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic [1:0] idx;
        bit         lit;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        e_push, e_pop;
    int          m_tick;
    logic [1:0]  m_idx;
    logic [15:0] m_shadow;
    int          m_bcnt;
    bit          m_phase;
    logic [3:0]  m_nib;
    bit          m_blank;

    initial begin
        m_tick = 0; m_idx = 0; m_shadow = 0; m_bcnt = 0; m_phase = 1;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_tick = 0; m_idx = 0; m_shadow = 0; m_bcnt = 0; m_phase = 1;
                sb_q.delete();
            end else begin
                e_push.lit = (m_tick != 3);
                e_push.an  = e_push.lit ? ~(4'b0001 << m_idx) : 4'b1111;
                e_push.idx = m_idx;
                m_nib      = m_shadow[m_idx*4 +: 4];
                m_blank    = lz_blank && (m_idx != 0) && ((m_shadow >> (4*m_idx)) == 16'h0);
`ifdef HEX_BLINK_EN
                if (!m_phase && blink_mask[m_idx]) m_blank = 1'b1;
`endif
                e_push.seg = m_blank ? 7'b1111111 : glyph_tab[m_nib];
                sb_q.push_back(e_push);
                if (load) m_shadow = value;
                if (m_tick == 3) begin
                    m_tick = 0;
                    m_idx  = m_idx + 2'd1;
                end else begin
                    m_tick++;
                end
                if (m_bcnt == 7) begin
                    m_bcnt  = 0;
                    m_phase = ~m_phase;
                end else begin
                    m_bcnt++;
                end
                #1;
                if (sb_q.size() == 0) begin
                    check("sb_empty", 32'd0, 32'd1);
                end else begin
                    e_pop = sb_q.pop_front();
                    check("sb_an", an, e_pop.an);
                    if (e_pop.lit) begin
                        check("sb_seg", seg, e_pop.seg);
                        check("sb_idx", digit_idx, e_pop.idx);
                    end
                end
            end
        end
    end

    task automatic do_load(input logic [15:0] v);
        @(negedge clk);
        value = v;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic wait_an(input logic [3:0] target, input string tag);
        bit hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk);
            if (an == target) hit = 1'b1;
        end
        check({tag, "_seen"}, {31'd0, hit}, 32'd1);
    endtask

    initial begin
        reset    = 1'b1;
        value    = 16'h0000;
        load     = 1'b0;
        lz_blank = 1'b0;
`ifdef HEX_BLINK_EN
        blink_mask = 4'b0000;
`endif
        repeat (2) @(negedge clk);
        check("rst_seg", seg, 7'b1111111);
        check("rst_an", an, 4'b1111);
        check("rst_idx", digit_idx, 2'd0);
        reset = 1'b0;
        @(negedge clk);
        check("first_an", an, 4'b1110);
        check("first_seg", seg, 7'b0000001);
        repeat (6) @(negedge clk);

        do_load(16'h12AF);
        wait_an(4'b1101, "12af_d1");
        check("12af_d1_seg", seg, 7'b0001000);
        wait_an(4'b0111, "12af_d3");
        check("12af_d3_seg", seg, 7'b1001111);
        repeat (16) @(negedge clk);

        lz_blank = 1'b1;
        do_load(16'h0030);
        wait_an(4'b0111, "lz30_d3");
        check("lz30_d3_seg", seg, 7'b1111111);
        wait_an(4'b1101, "lz30_d1");
        check("lz30_d1_seg", seg, 7'b0000110);
        wait_an(4'b1110, "lz30_d0");
        check("lz30_d0_seg", seg, 7'b0000001);
        do_load(16'h0000);
        wait_an(4'b1101, "lz0_d1");
        check("lz0_d1_seg", seg, 7'b1111111);
        wait_an(4'b1110, "lz0_d0");
        check("lz0_d0_seg", seg, 7'b0000001);
        lz_blank = 1'b0;

        for (int n = 0; n < 16; n++) begin
            do_load(16'(n));
            wait_an(4'b1110, "nib");
            check($sformatf("nib%0h_seg", n), seg, glyph_tab[n]);
        end
        do_load(16'h000C);
        wait_an(4'b1110, "glyph_c");
        check("glyph_c", seg, 7'b0110001);
        do_load(16'h000D);
        wait_an(4'b1110, "glyph_d");
        check("glyph_d", seg, 7'b1000010);

        do_load(16'h4321);
        wait_an(4'b1011, "mid_d2");
        #1 reset = 1'b1;
        #1;
        check("async_seg", seg, 7'b1111111);
        check("async_an", an, 4'b1111);
        check("async_idx", digit_idx, 2'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("restart_an", an, 4'b1110);
        check("restart_seg", seg, 7'b0000001);
        repeat (20) @(negedge clk);

`ifdef HEX_BLINK_EN
        blink_mask = 4'b0001;
        do_load(16'h5555);
        repeat (48) @(negedge clk);
        blink_mask = 4'b0000;
`endif

        do_load(16'hBEEF);
        repeat (20) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
